fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the RV32 core, replacing the bare PC register + PC+4 adder + PCSrc mux.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit_chk.sv | 48 ++++
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    localparam int                    XLEN_DEF     = 32;
    localparam logic [XLEN_DEF-1:0]   RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] inst;
        logic [XLEN_DEF-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; pointers carry an extra wrap bit to tell full from empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count = wr_ptr_r - rd_ptr_r;
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // A push/pop pair always completes together, even at full or empty.
    always_comb begin
        do_push_s = push && (!full || pop);
        do_pop_s  = pop && (!empty || push);
    end

    // Read/write pointers; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit_chk.sv
// Protocol and bookkeeping assertions for fetch_unit.
module fetch_unit_chk #(
    parameter int XLEN = 32,
    parameter int OW   = 2,
    parameter int PW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            req,
    input  logic            gnt,
    input  logic [XLEN-1:0] addr,
    input  logic            rvalid,
    input  logic            redirect,
    input  logic [OW-1:0]   outst,
    input  logic [PW-1:0]   pc_count,
    input  logic            pc_full,
    input  logic            pc_empty,
    input  logic            q_push,
    input  logic            q_pop,
    input  logic            q_full
);

    a_rvalid_outst: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> (outst != {OW{1'b0}}))
        else $error("imem response with no request outstanding");

    a_rvalid_pc: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> !pc_empty)
        else $error("imem response with in-flight PC FIFO empty");

    a_gnt_pc: assert property (@(posedge clk) disable iff (!rst_n)
        (req && gnt && !rvalid) |-> !pc_full)
        else $error("grant with in-flight PC FIFO full");

    a_pc_track: assert property (@(posedge clk) disable iff (!rst_n)
        32'(pc_count) == 32'(outst))
        else $error("in-flight PC count diverged from outstanding counter");

    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req && !gnt && !redirect && start) |=> (req && $stable(addr)))
        else $error("request retracted or address changed before grant");

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (q_push && !redirect) |-> (!q_full || q_pop))
        else $error("instruction queue overflow");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// in-order response queue toward decode, and redirect squashing of wrong-path work.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter int              FQ_DEPTH  = 4,
    parameter int              MAX_OUTST = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);

    localparam int CW      = $clog2(FQ_DEPTH) + 1;
    localparam int OW      = $clog2(MAX_OUTST + 1);
    localparam int SW      = ((CW > OW) ? CW : OW) + 1;
    // In-flight PC FIFO rounded up to a power of two so the wrap-bit pointers work.
    localparam int PCD_AW  = (MAX_OUTST <= 2) ? 1 : $clog2(MAX_OUTST);
    localparam int PCD     = 1 << PCD_AW;

    state_e            state_r;
    state_e            state_nx_s;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   pc_nx_s;
    logic [OW-1:0]     outst_r;
    logic [OW-1:0]     outst_nx_s;
    logic [OW-1:0]     discard_r;
    logic [OW-1:0]     discard_nx_s;
    logic              req_s;
    logic              fire_s;
    logic              q_push_s;
    logic              q_pop_s;
    logic              q_full_s;
    logic              q_empty_s;
    logic [CW-1:0]     q_count_s;
    logic [2*XLEN-1:0] q_rdata_s;
    logic [XLEN-1:0]   pcf_rdata_s;
    logic              pcf_full_s;
    logic              pcf_empty_s;
    logic [PCD_AW:0]   pcf_count_s;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: fetch runs exactly while start_i is high.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) state_nx_s = RUN;
                else         state_nx_s = IDLE;
            end
            RUN: begin
                if (!start_i) state_nx_s = IDLE;
                else          state_nx_s = RUN;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs: request only while queue slots cover every in-flight response.
    always_comb begin
        req_s = 1'b0;
        if ((state_r == RUN) &&
            ((SW'(q_count_s) + SW'(outst_r)) < SW'(FQ_DEPTH)) &&
            (outst_r < OW'(MAX_OUTST))) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        fire_s = req_s && imem_gnt_i;
    end

    // Next-state values for pc, outstanding and discard counters.
    always_comb begin
        outst_nx_s = outst_r + OW'(fire_s) - OW'(imem_rvalid_i);
        if (redirect_i) begin
            // Everything still in flight after this cycle is wrong-path.
            discard_nx_s = outst_nx_s;
        end else if (imem_rvalid_i && (discard_r != {OW{1'b0}})) begin
            discard_nx_s = discard_r - OW'(1'b1);
        end else begin
            discard_nx_s = discard_r;
        end
        if (redirect_i) begin
            pc_nx_s = redirect_pc_i & ~(XLEN'(3));
        end else if (fire_s) begin
            pc_nx_s = pc_r + XLEN'(4);
        end else begin
            pc_nx_s = pc_r;
        end
        q_push_s = imem_rvalid_i && (discard_r == {OW{1'b0}});
        q_pop_s  = inst_valid_o && inst_ready_i;
    end

    // PC and request-accounting registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_r      <= RESET_PC;
            outst_r   <= {OW{1'b0}};
            discard_r <= {OW{1'b0}};
        end else begin
            pc_r      <= pc_nx_s;
            outst_r   <= outst_nx_s;
            discard_r <= discard_nx_s;
        end
    end

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FQ_DEPTH)) u_inst_q (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (q_push_s),
        .pop   (q_pop_s),
        .flush (redirect_i),
        .wdata ({imem_rdata_i, pcf_rdata_s}),
        .rdata (q_rdata_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(PCD)) u_pc_q (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (fire_s),
        .pop   (imem_rvalid_i),
        .flush (1'b0),
        .wdata (pc_r),
        .rdata (pcf_rdata_s),
        .full  (pcf_full_s),
        .empty (pcf_empty_s),
        .count (pcf_count_s)
    );

    assign imem_req_o   = req_s;
    assign imem_addr_o  = pc_r;
    assign inst_valid_o = !q_empty_s;
    assign inst_o       = q_empty_s ? {XLEN{1'b0}} : q_rdata_s[2*XLEN-1:XLEN];
    assign inst_pc_o    = q_empty_s ? {XLEN{1'b0}} : q_rdata_s[XLEN-1:0];

    fetch_unit_chk #(.XLEN(XLEN), .OW(OW), .PW(PCD_AW+1)) u_chk (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .start    (start_i),
        .req      (req_s),
        .gnt      (imem_gnt_i),
        .addr     (pc_r),
        .rvalid   (imem_rvalid_i),
        .redirect (redirect_i),
        .outst    (outst_r),
        .pc_count (pcf_count_s),
        .pc_full  (pcf_full_s),
        .pc_empty (pcf_empty_s),
        .q_push   (q_push_s),
        .q_pop    (q_pop_s),
        .q_full   (q_full_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure, redirect, stall, stop, PC wrap.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ivalid;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        ready = 1'b0;

    logic        w_rst_n = 1'b0;
    logic        w_start = 1'b0;
    logic        w_gnt = 1'b0;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ivalid;
    logic [31:0] w_inst;
    logic [31:0] w_ipc;

    int          total = 0;
    int          bad = 0;
    int          fires = 0;
    logic [31:0] last_fire = 32'h0;
    logic        resp_en = 1'b0;
    logic [31:0] pend[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .inst_valid_o(ivalid), .inst_o(inst), .inst_pc_o(ipc), .inst_ready_i(ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(w_rst_n), .start_i(w_start),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
        .imem_rvalid_i(w_zero), .imem_rdata_i(w_zero32),
        .redirect_i(w_zero), .redirect_pc_i(w_zero32),
        .inst_valid_o(w_ivalid), .inst_o(w_inst), .inst_pc_o(w_ipc), .inst_ready_i(w_zero)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: log a grant before the edge, then present the next in-order response.
    task automatic tick();
        @(negedge clk);
        if (req && gnt) begin
            pend.push_back(addr);
            fires++;
            last_fire = addr;
        end
        @(posedge clk);
        #1;
        if (resp_en && pend.size() > 0) begin
            rvalid = 1'b1;
            rdata  = inst_of(pend.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = 32'h0;
        end
    endtask

    task automatic do_reset(input logic st, input logic g, input logic rdy, input logic ren);
        rst_n = 1'b0; start = 1'b0; gnt = 1'b0; ready = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; rvalid = 1'b0; rdata = 32'h0; resp_en = 1'b0;
        pend.delete();
        repeat (2) tick();
        fires = 0;
        rst_n = 1'b1; start = st; gnt = g; ready = rdy; resp_en = ren;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        found;

        // Reset state
        repeat (2) tick();
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_valid", {31'b0, ivalid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_ipc", ipc, 32'h0);

        // 1: streaming fetch, one instruction per cycle
        do_reset(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("t1_req0", {31'b0, req}, 32'h1);
        chk("t1_addr0", addr, 32'h0);
        tick();
        chk("t1_addr1", addr, 32'h4);
        chk("t1_lat", {31'b0, ivalid}, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t1_valid", {31'b0, ivalid}, 32'h1);
            chk("t1_ipc", ipc, 32'(4 * i));
            chk("t1_inst", inst, inst_of(32'(4 * i)));
            chk("t1_addr", addr, 32'(8 + 4 * i));
            tick();
        end
        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("t1_arst_req", {31'b0, req}, 32'h0);
        chk("t1_arst_addr", addr, 32'h0);
        chk("t1_arst_valid", {31'b0, ivalid}, 32'h0);
        chk("t1_arst_inst", inst, 32'h0);
        chk("t1_arst_ipc", ipc, 32'h0);
        do_reset(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("t1_rerun_addr0", addr, 32'h0);
        tick();
        chk("t1_rerun_addr1", addr, 32'h4);

        // 2: back-pressure with a 4-entry queue
        do_reset(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (10) tick();
        chk("t2_grants", 32'(fires), 32'd4);
        chk("t2_req_off", {31'b0, req}, 32'h0);
        chk("t2_head_pc", ipc, 32'h0);
        fires = 0;
        ready = 1'b1;
        repeat (2) tick();
        ready = 1'b0;
        repeat (8) tick();
        chk("t2_more_grants", 32'(fires), 32'd2);
        chk("t2_last_addr", last_fire, 32'h14);
        chk("t2_req_off2", {31'b0, req}, 32'h0);
        chk("t2_head_pc2", ipc, 32'h8);

        // 3: redirect with two requests outstanding
        do_reset(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        chk("t3_cap", {31'b0, req}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("t3_addr", addr, 32'h100);
        chk("t3_valid0", {31'b0, ivalid}, 32'h0);
        resp_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!found) begin
                if (ivalid) begin
                    found = 1'b1;
                    chk("t3_first_pc", ipc, 32'h100);
                    chk("t3_first_inst", inst, inst_of(32'h100));
                end else begin
                    tick();
                end
            end
        end
        chk("t3_delivered", {31'b0, found}, 32'h1);

        // 4: grant stall holds request and address
        do_reset(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_req_hold", {31'b0, req}, 32'h1);
            chk("t4_addr_hold", addr, 32'h0);
            tick();
        end
        gnt = 1'b1;
        chk("t4_addr_pre", addr, 32'h0);
        tick();
        chk("t4_addr_post", addr, 32'h4);
        chk("t4_fires", 32'(fires), 32'd1);

        // 5: start drop with two outstanding
        do_reset(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        chk("t5_issued", 32'(fires), 32'd2);
        start = 1'b0;
        tick();
        chk("t5_state", {31'b0, dut.state_r}, {31'b0, IDLE});
        resp_en = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_req", {31'b0, req}, 32'h0);
            if (ivalid) begin
                chk("t5_ipc", ipc, exp_pc);
                chk("t5_inst", inst, inst_of(exp_pc));
                exp_pc = exp_pc + 32'h4;
            end
            tick();
        end
        chk("t5_count", exp_pc, 32'h8);

        // 6: PC wrap-around from the top of the address space
        chk("t6_rst_addr", w_addr, 32'hFFFF_FFFC);
        w_rst_n = 1'b1; w_start = 1'b1; w_gnt = 1'b1;
        tick();
        chk("t6_req", {31'b0, w_req}, 32'h1);
        chk("t6_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("t6_addr1", w_addr, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
